// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one memory read per instruction, holds the
// fetched word until downstream takes it, and steers the external PC register.
module instruction_fetch #(
  parameter int         INC        = 4,
  parameter logic [7:0] RESET_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  pc_q,
  output logic [7:0]  pc_d,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [7:0]  instr_pc,
  input  logic        br_take,
  input  logic [7:0]  br_target
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [7:0] INC_B = 8'(INC);

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  ipc_q, ipc_d;
  logic [7:0]  redir_q, redir_d;
  logic        pend_q, pend_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      instr_q <= '0;
      ipc_q   <= '0;
      redir_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      redir_q <= redir_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    redir_d = redir_q;
    pend_d  = pend_q;
    if (clr) begin
      pc_d = RESET_ADDR;
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (mem_ack) begin
            // A redirect seen during the fetch makes the returned word stale;
            // the current-cycle target is the newest and beats the latched one.
            if (br_take) begin
              pc_d   = br_target;
              pend_d = 1'b0;
            end else if (pend_q) begin
              pc_d   = redir_q;
              pend_d = 1'b0;
            end else begin
              instr_d = mem_rdata;
              ipc_d   = pc_q;
              state_d = HOLD;
            end
          end else if (br_take) begin
            redir_d = br_target;
            pend_d  = 1'b1;
          end
        end
        HOLD: begin
          if (br_take) begin
            pc_d    = br_target;
            state_d = FETCH;
          end else if (instr_ready) begin
            pc_d    = pc_q + INC_B;
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mem_req     = (state_q == FETCH);
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run checked against an address-stream reference model.
module tb_instruction_fetch;

  logic        clk;
  logic        clr;
  logic [7:0]  pc_q;
  logic [7:0]  pc_d;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        br_take;
  logic [7:0]  br_target;

  int checks = 0;
  int fails  = 0;

  instruction_fetch #(.INC(4), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .clr(clr), .pc_q(pc_q), .pc_d(pc_d),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .br_take(br_take), .br_target(br_target)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // The program counter register that the fetch unit steers.
  always @(posedge clk) pc_q <= pc_d;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a ^ 8'hC3, 8'h5A, ~a, a};
  endfunction

  // Apply inputs mid-cycle; outputs are sampled 1 time unit later.
  task automatic drv(input logic c, input logic ack, input logic [31:0] rd,
                     input logic rdy, input logic br, input logic [7:0] tg);
    @(negedge clk);
    clr = c; mem_ack = ack; mem_rdata = rd; instr_ready = rdy; br_take = br; br_target = tg;
    #1;
  endtask

  task automatic do_reset();
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
  endtask

  // From the first FETCH cycle after reset, redirect so the next fetch is at a.
  task automatic goto_addr(input logic [7:0] a);
    drv(0, 1, 32'hDEAD_BEEF, 0, 1, a);
  endtask

  task automatic test_reset();
    drv(1, 1, 32'h1234_5678, 1, 1, 8'h99);
    checks++; if (pc_d !== 8'h00) begin fails++; $display("FAIL reset_pc_d got=%h want=00", pc_d); end
    drv(1, 1, 32'h1234_5678, 1, 1, 8'h99);
    checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL reset_ctrl req=%b valid=%b want 0/0", mem_req, instr_valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 8'h00) begin fails++; $display("FAIL reset_regs instr=%h pc=%h want 0/0", instr, instr_pc); end
    // idle cycle: a redirect here is ignored
    drv(0, 0, 0, 0, 1, 8'h77);
    checks++; if (mem_req !== 1'b0 || pc_d !== 8'h00) begin fails++; $display("FAIL idle req=%b pc_d=%h want 0/00", mem_req, pc_d); end
    drv(0, 0, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin fails++; $display("FAIL first_fetch req=%b addr=%h want 1/00", mem_req, mem_addr); end
  endtask

  task automatic test_sequential();
    logic [7:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 8'(i * 4);
      drv(0, 0, 0, 0, 0, 0);
      checks++; if (mem_req !== 1'b1 || mem_addr !== a || pc_d !== a) begin fails++; $display("FAIL seq_req req=%b addr=%h pc_d=%h want 1/%h/%h", mem_req, mem_addr, pc_d, a, a); end
      drv(0, 1, mem_word(a), 0, 0, 0);
      checks++; if (pc_d !== a) begin fails++; $display("FAIL seq_ack_pc got=%h want=%h", pc_d, a); end
      drv(0, 0, 0, 1, 0, 0);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== a || instr !== mem_word(a) || pc_d !== a + 8'd4)
        begin fails++; $display("FAIL seq_hs valid=%b pc=%h instr=%h pc_d=%h want 1/%h/%h/%h", instr_valid, instr_pc, instr, pc_d, a, mem_word(a), a + 8'd4); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    goto_addr(8'hFC);
    drv(0, 1, mem_word(8'hFC), 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    checks++; if (instr_pc !== 8'hFC || pc_d !== 8'h00) begin fails++; $display("FAIL wrap pc=%h pc_d=%h want FC/00", instr_pc, pc_d); end
    drv(0, 0, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin fails++; $display("FAIL wrap_next req=%b addr=%h want 1/00", mem_req, mem_addr); end
  endtask

  task automatic test_stall();
    do_reset();
    goto_addr(8'h20);
    drv(0, 1, mem_word(8'h20), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0);
      checks++; if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instr !== mem_word(8'h20) || instr_pc !== 8'h20 || pc_d !== 8'h20)
        begin fails++; $display("FAIL stall valid=%b req=%b instr=%h pc=%h pc_d=%h", instr_valid, mem_req, instr, instr_pc, pc_d); end
    end
    drv(0, 0, 0, 1, 0, 0);
    checks++; if (pc_d !== 8'h24) begin fails++; $display("FAIL stall_release pc_d=%h want=24", pc_d); end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    goto_addr(8'h10);
    drv(0, 0, 0, 0, 1, 8'h40);
    checks++; if (mem_addr !== 8'h10 || pc_d !== 8'h10) begin fails++; $display("FAIL pend_latch addr=%h pc_d=%h want 10/10", mem_addr, pc_d); end
    drv(0, 0, 0, 0, 0, 0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h10) begin fails++; $display("FAIL pend_hold req=%b addr=%h want 1/10", mem_req, mem_addr); end
    drv(0, 1, mem_word(8'h10), 1, 0, 0);
    checks++; if (pc_d !== 8'h40) begin fails++; $display("FAIL pend_ack pc_d=%h want=40", pc_d); end
    drv(0, 0, 0, 1, 0, 0);
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h40) begin fails++; $display("FAIL pend_next valid=%b req=%b addr=%h want 0/1/40", instr_valid, mem_req, mem_addr); end
  endtask

  task automatic test_redirect_last();
    do_reset();
    goto_addr(8'h10);
    drv(0, 0, 0, 0, 1, 8'h40);
    drv(0, 0, 0, 0, 1, 8'h80);
    drv(0, 1, mem_word(8'h10), 0, 0, 0);
    checks++; if (pc_d !== 8'h80) begin fails++; $display("FAIL last_wins pc_d=%h want=80", pc_d); end
    drv(0, 1, mem_word(8'h80), 0, 0, 0);
    checks++; if (mem_addr !== 8'h80) begin fails++; $display("FAIL last_addr addr=%h want=80", mem_addr); end
    drv(0, 0, 0, 1, 0, 0);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h80 || instr !== mem_word(8'h80)) begin fails++; $display("FAIL last_instr valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_branch_hold();
    do_reset();
    goto_addr(8'h50);
    drv(0, 1, mem_word(8'h50), 0, 0, 0);
    drv(0, 0, 0, 0, 1, 8'hA0);
    checks++; if (pc_d !== 8'hA0) begin fails++; $display("FAIL hold_br pc_d=%h want=A0", pc_d); end
    drv(0, 0, 0, 0, 0, 0);
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'hA0) begin fails++; $display("FAIL hold_br_next valid=%b req=%b addr=%h", instr_valid, mem_req, mem_addr); end
  endtask

  task automatic test_clr();
    do_reset();
    goto_addr(8'h30);
    drv(0, 1, mem_word(8'h30), 0, 0, 0);
    drv(1, 0, 0, 1, 0, 0);
    checks++; if (pc_d !== 8'h00) begin fails++; $display("FAIL clr_hold pc_d=%h want=00", pc_d); end
    drv(0, 1, mem_word(8'h30), 0, 0, 0);
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || instr !== 32'h0) begin fails++; $display("FAIL clr_hold_next valid=%b req=%b instr=%h", instr_valid, mem_req, instr); end
    drv(1, 1, mem_word(8'h00), 0, 0, 0);
    checks++; if (pc_d !== 8'h00) begin fails++; $display("FAIL clr_fetch pc_d=%h want=00", pc_d); end
    drv(0, 1, 32'hBAD0_0BAD, 0, 0, 0);
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL clr_fetch_next valid=%b req=%b", instr_valid, mem_req); end
    drv(0, 0, 0, 0, 0, 0);
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h00) begin fails++; $display("FAIL clr_late_ack valid=%b req=%b addr=%h", instr_valid, mem_req, mem_addr); end
  endtask

  // Reference: the program should execute a stream of addresses that steps by
  // 4 and jumps to the newest branch target; every delivered instruction must
  // be the next address of that stream, carrying that address's memory word.
  task automatic test_random();
    logic [7:0] exp_addr, tg, pq;
    logic ack, br, rdy, req, vld, prev_req, prev_ack;
    logic [7:0] addr, prev_addr;
    int wait_cnt, delivered;
    do_reset();
    exp_addr = 8'h00; wait_cnt = 1; delivered = 0;
    prev_req = 0; prev_ack = 0; prev_addr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      req = mem_req; vld = instr_valid; addr = mem_addr; pq = pc_q;
      ack = 0;
      if (req) begin
        if (wait_cnt == 0) begin ack = 1; wait_cnt = $urandom_range(0, 3); end
        else wait_cnt--;
      end
      br  = ($urandom_range(0, 7) == 0);
      tg  = 8'($urandom) & 8'hFC;
      rdy = ($urandom_range(0, 9) < 7);
      clr = 0; mem_ack = ack; mem_rdata = mem_word(addr); instr_ready = rdy; br_take = br; br_target = tg;
      #1;
      if (prev_req && req && !prev_ack) begin
        checks++; if (addr !== prev_addr) begin fails++; $display("FAIL rnd_addr_stable cyc=%0d addr=%h want=%h", cyc, addr, prev_addr); end
      end
      if (vld && (rdy || br)) begin
        checks++; if (instr_pc !== exp_addr || instr !== mem_word(exp_addr))
          begin fails++; $display("FAIL rnd_instr cyc=%0d pc=%h instr=%h want %h/%h", cyc, instr_pc, instr, exp_addr, mem_word(exp_addr)); end
        if (rdy) delivered++;
        exp_addr = exp_addr + 8'd4;
      end
      if (br) begin
        exp_addr = tg;
        checks++; if (pc_d !== ((vld || ack) ? tg : pq)) begin fails++; $display("FAIL rnd_br_pc cyc=%0d pc_d=%h want=%h", cyc, pc_d, (vld || ack) ? tg : pq); end
      end else if (vld && rdy) begin
        checks++; if (pc_d !== exp_addr) begin fails++; $display("FAIL rnd_step_pc cyc=%0d pc_d=%h want=%h", cyc, pc_d, exp_addr); end
      end else if (ack) begin
        // a useful fetch leaves the PC alone; a stale one jumps to the stream head
        checks++; if (pc_d !== exp_addr) begin fails++; $display("FAIL rnd_ack_pc cyc=%0d pc_d=%h want=%h", cyc, pc_d, exp_addr); end
      end else begin
        checks++; if (pc_d !== pq) begin fails++; $display("FAIL rnd_hold_pc cyc=%0d pc_d=%h want=%h", cyc, pc_d, pq); end
      end
      prev_req = req; prev_ack = ack; prev_addr = addr;
    end
    checks++; if (delivered < 20) begin fails++; $display("FAIL rnd_progress delivered=%0d want>=20", delivered); end
  endtask

  initial begin
    clr = 1; mem_ack = 0; mem_rdata = 0; instr_ready = 0; br_take = 0; br_target = 0;
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_redirect_pending();
    test_redirect_last();
    test_branch_hold();
    test_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
